// File: rtl/image_loader.sv
// rtl/image_loader.sv - Loads memory and register-file images from a word stream while holding the CPU in reset.
// Optional trailing-checksum check is enabled by defining IMAGE_LOADER_CHECKSUM_EN.
module image_loader #(
    parameter int MEM_AW = 13,
    parameter int RF_AW  = 5,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_addr,
    output logic [31:0]       rf_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic [2:0]        state;
    logic [MEM_AW-1:0] addr;
    logic [CNT_W-1:0]  remain;
    logic              tgt;

    logic              hdr_last;
    logic              hdr_tgt;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [MEM_AW-1:0] hdr_base;
    logic [31:0]       hdr_end;
    logic              hdr_bad;
    logic              unused_bits;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [31:0]       sum;
`endif

    assign hdr_last    = in_data[31];
    assign hdr_tgt     = in_data[30];
    assign hdr_cnt     = in_data[16 +: CNT_W];
    assign hdr_base    = in_data[MEM_AW-1:0];
    assign unused_bits = ^in_data[15:MEM_AW];

    // End address is exclusive; a record may finish exactly at the top of its target space.
    assign hdr_end = 32'(hdr_base) + 32'(hdr_cnt) + 32'd1;
    assign hdr_bad = hdr_tgt ? (hdr_end > (32'd1 << RF_AW)) : (hdr_end > (32'd1 << MEM_AW));

    assign in_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
    assign cpu_rst  = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HDR;
            addr      <= '0;
            remain    <= '0;
            tgt       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            rf_we  <= 1'b0;
            case (state)
                S_HDR: begin
                    if (in_valid) begin
                        if (hdr_last) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            addr   <= hdr_base;
                            remain <= hdr_cnt;
                            tgt    <= hdr_tgt;
                            state  <= hdr_bad ? S_ERR : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        mem_we    <= !tgt;
                        rf_we     <= tgt;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        rf_addr   <= addr[RF_AW-1:0];
                        rf_wdata  <= in_data;
                        addr      <= addr + 1'b1;
                        remain    <= remain - 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                        sum       <= sum + in_data;
`endif
                        // remain holds count-1, so zero marks the final word of the record
                        if (remain == '0) begin
                            state <= S_HDR;
                        end
                    end
                end
`ifdef IMAGE_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (in_valid) begin
                        state <= (in_data == sum) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (start) begin
                        state  <= S_HDR;
                        addr   <= '0;
                        remain <= '0;
                        tgt    <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                        sum    <= '0;
`endif
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - Self-checking bench for image_loader; honours IMAGE_LOADER_CHECKSUM_EN.
module tb_image_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    image_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: image-level view (mode, record base, words seen so far, running sum).
    localparam int M_HDR = 0, M_DATA = 1, M_DONE = 2, M_ERR = 3, M_CHK = 4;
    int          m_mode = M_HDR;
    int          m_base = 0, m_n = 0, m_k = 0;
    bit          m_tgt = 0;
    logic [31:0] m_sum = '0;
    bit          e_mem_we = 0, e_rf_we = 0, e_zero = 1;
    int          e_addr = 0;
    logic [31:0] e_data = '0;

    function automatic bit m_accepts(input int mode);
        return (mode == M_HDR) || (mode == M_DATA) || (mode == M_CHK);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_HDR; m_sum <= '0; m_k <= 0;
            e_mem_we <= 0; e_rf_we <= 0; e_zero <= 1; e_addr <= 0; e_data <= '0;
        end else begin
            automatic int base = int'(in_data[12:0]);
            automatic int n    = int'(in_data[29:16]) + 1;
            automatic int lim  = in_data[30] ? 32 : 8192;
            e_mem_we <= 0;
            e_rf_we  <= 0;
            if (in_valid && m_accepts(m_mode)) begin
                case (m_mode)
                    M_HDR: begin
                        if (in_data[31]) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                            m_mode <= M_CHK;
`else
                            m_mode <= M_DONE;
`endif
                        end else begin
                            m_base <= base; m_n <= n; m_k <= 0; m_tgt <= in_data[30];
                            m_mode <= (base + n > lim) ? M_ERR : M_DATA;
                        end
                    end
                    M_DATA: begin
                        e_addr <= m_base + m_k; e_data <= in_data;
                        e_mem_we <= !m_tgt; e_rf_we <= m_tgt; e_zero <= 0;
                        m_sum <= m_sum + in_data;
                        m_k <= m_k + 1;
                        if (m_k + 1 == m_n) m_mode <= M_HDR;
                    end
                    default: m_mode <= (in_data == m_sum) ? M_DONE : M_ERR;
                endcase
            end else if (start && (m_mode == M_DONE || m_mode == M_ERR)) begin
                m_mode <= M_HDR; m_sum <= '0;
            end
        end
    end

    typedef struct { int cyc; bit rf; int addr; logic [31:0] data; } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_accepts(m_mode)));
        chk("cpu_rst", 32'(cpu_rst), 32'(m_mode != M_DONE));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("err", 32'(err), 32'(m_mode == M_ERR));
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        chk("rf_we", 32'(rf_we), 32'(e_rf_we));
        if (e_mem_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", mem_wdata, e_data);
        end
        if (e_rf_we) begin
            chk("rf_addr", 32'(rf_addr), 32'(e_addr));
            chk("rf_wdata", rf_wdata, e_data);
        end
        if (e_zero) begin
            chk("zero_outs", {mem_wdata | rf_wdata} | 32'(mem_addr) | 32'(rf_addr), 32'd0);
        end
        if (mem_we) wlog.push_back('{cyc, 1'b0, int'(mem_addr), mem_wdata});
        if (rf_we)  wlog.push_back('{cyc, 1'b1, int'(rf_addr), rf_wdata});
    end

    task automatic send(input logic [31:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: word 0x%08h not accepted within 50 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_img(input logic [31:0] s);
        send(32'h8000_0000);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        send(s);
`else
        if (s == 32'hFFFF_FFFF) $display("note: unexpected sum marker");
`endif
    endtask

    task automatic chk_wr(input string name, input int idx, input bit rf, input int a, input logic [31:0] d);
        if (idx >= wlog.size()) begin
            chk({name, "_present"}, 32'(wlog.size()), 32'(idx + 1));
        end else begin
            chk({name, "_tgt"}, 32'(wlog[idx].rf), 32'(rf));
            chk({name, "_addr"}, 32'(wlog[idx].addr), 32'(a));
            chk({name, "_data"}, wlog[idx].data, d);
        end
    endtask

    initial begin
        int b;
        // Reset state
        idle(3);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b1;
        idle(1);

        // Memory record, three back-to-back writes
        send(32'h0002_0010); send(32'h11); send(32'h22); send(32'h33);
        finish_img(32'h66);
        idle(1);
        chk("mem_nwr", 32'(wlog.size()), 32'd3);
        chk_wr("mem0", 0, 0, 32'h10, 32'h11);
        chk_wr("mem1", 1, 0, 32'h11, 32'h22);
        chk_wr("mem2", 2, 0, 32'h12, 32'h33);
        if (wlog.size() == 3) begin
            chk("mem_b2b_a", 32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
            chk("mem_b2b_b", 32'(wlog[2].cyc - wlog[1].cyc), 32'd1);
        end
        chk("mem_done", 32'(done), 32'd1);
        chk("mem_cpu_rst", 32'(cpu_rst), 32'd0);

        // Register record
        pulse_start();
        chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        send(32'h4001_0005); send(32'hAAAA); send(32'hBBBB);
        finish_img(32'h0001_6665);
        idle(1);
        chk("rf_nwr", 32'(wlog.size()), 32'd5);
        chk_wr("rf0", 3, 1, 5, 32'hAAAA);
        chk_wr("rf1", 4, 1, 6, 32'hBBBB);
        chk("rf_done", 32'(done), 32'd1);

        // Register range error, then restart
        pulse_start();
        send(32'h4001_001F);
        idle(2);
        chk("rng_err", 32'(err), 32'd1);
        chk("rng_in_ready", 32'(in_ready), 32'd0);
        chk("rng_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rng_nwr", 32'(wlog.size()), 32'd5);
        pulse_start();
        chk("rng_clear_err", 32'(err), 32'd0);
        chk("rng_hdr_ready", 32'(in_ready), 32'd1);

        // Stalled 4-word record
        b = wlog.size();
        send(32'h0003_0100);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            send(32'hA0 + 32'(i));
        end
        finish_img(32'h286);
        chk("stall_nwr", 32'(wlog.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk_wr("stall", b + i, 0, 32'h100 + i, 32'hA0 + 32'(i));
        if (wlog.size() == b + 4) chk("stall_gap", 32'(wlog[b + 1].cyc - wlog[b].cyc), 32'd2);
        chk("stall_done", 32'(done), 32'd1);

        // Reset mid-record, then a fresh image
        pulse_start();
        send(32'h0003_0200); send(32'h1); send(32'h2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_we", {30'd0, mem_we, rf_we}, 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        idle(2);
        rst = 1'b1;
        b = wlog.size();
        send(32'h0000_0300); send(32'h5A);
        finish_img(32'h5A);
        chk_wr("post_rst", b, 0, 32'h300, 32'h5A);
        chk("post_rst_done", 32'(done), 32'd1);

        // Memory top boundary: exact fit loads, one past errors
        pulse_start();
        b = wlog.size();
        send(32'h0000_1FFF); send(32'h77);
        finish_img(32'h77);
        chk_wr("top_fit", b, 0, 32'h1FFF, 32'h77);
        chk("top_fit_done", 32'(done), 32'd1);
        pulse_start();
        send(32'h0001_1FFF);
        idle(1);
        chk("top_over_err", 32'(err), 32'd1);

`ifdef IMAGE_LOADER_CHECKSUM_EN
        pulse_start();
        send(32'h0002_0000); send(32'h1); send(32'h2); send(32'h3);
        send(32'h8000_0000); send(32'h6);
        chk("ck_good_done", 32'(done), 32'd1);
        pulse_start();
        send(32'h0002_0000); send(32'h1); send(32'h2); send(32'h3);
        send(32'h8000_0000); send(32'h7);
        chk("ck_bad_err", 32'(err), 32'd1);
        chk("ck_bad_cpu_rst", 32'(cpu_rst), 32'd1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
